// File: rtl/rsa_engine_arbiter.sv
// Round-robin arbiter sharing one modexp engine between encrypt and decrypt requesters.
// Optional watchdog abort enabled by defining RSA_ARB_TIMEOUT_EN.
module rsa_engine_arbiter #(
  parameter int N_BIT       = 1024,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_req_valid,
  output logic             enc_req_ready,
  input  logic [N_BIT-1:0] enc_req_data,
  input  logic             dec_req_valid,
  output logic             dec_req_ready,
  input  logic [N_BIT-1:0] dec_req_data,
  output logic             eng_start,
  output logic             eng_mode,
  output logic [N_BIT-1:0] eng_data_in,
  input  logic [N_BIT-1:0] eng_data_out,
  input  logic             eng_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_mode,
  output logic [N_BIT-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, RESP, DRAIN} state_t;

  state_t state_q, state_d;
  logic   last_grant;
  logic   grant_enc, grant_dec, accept;
  logic   wd_hit;

  // Tie goes to whichever side did not win last; last_grant uses the mode encoding.
  assign grant_enc = enc_req_valid && (!dec_req_valid || last_grant);
  assign grant_dec = dec_req_valid && (!enc_req_valid || !last_grant);
  assign accept    = (state_q == IDLE) && (enc_req_valid || dec_req_valid);

`ifdef RSA_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt;

  // Fires on the RUN cycle where the count would reach TIMEOUT_CYC.
  assign wd_hit = (wd_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (accept)
        wd_cnt <= '0;
      else if (state_q == RUN)
        wd_cnt <= wd_cnt + 32'd1;
      if (state_q == RUN && !eng_done && wd_hit)
        rsp_err <= 1'b1;
      else if (state_q == RESP && rsp_ready)
        rsp_err <= 1'b0;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)              state_d = RUN;
      RUN:     if (eng_done || wd_hit)  state_d = RESP;
      RESP:    if (rsp_ready)           state_d = DRAIN;
      DRAIN:   if (!eng_done)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  always_comb begin
    enc_req_ready = rst_n && (state_q == IDLE) && grant_enc;
    dec_req_ready = rst_n && (state_q == IDLE) && grant_dec;
    busy          = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eng_start   <= 1'b0;
      eng_mode    <= 1'b0;
      eng_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_mode    <= 1'b0;
      rsp_data    <= '0;
      last_grant  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          eng_start   <= 1'b1;
          eng_mode    <= grant_dec;
          eng_data_in <= grant_dec ? dec_req_data : enc_req_data;
          last_grant  <= grant_dec;
        end
        RUN: if (eng_done) begin
          rsp_data  <= eng_data_out;
          rsp_mode  <= eng_mode;
          rsp_valid <= 1'b1;
          eng_start <= 1'b0;
        end else if (wd_hit) begin
          rsp_data  <= '0;
          rsp_mode  <= eng_mode;
          rsp_valid <= 1'b1;
          eng_start <= 1'b0;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_engine_arbiter.sv
// Directed bench for rsa_engine_arbiter with a behavioural modexp engine (n=3551, e=5, d=1373).
module tb_rsa_engine_arbiter;
  localparam int N = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enc_req_valid = 1'b0, dec_req_valid = 1'b0;
  logic [N-1:0] enc_req_data = '0, dec_req_data = '0;
  logic         enc_req_ready, dec_req_ready;
  logic         eng_start, eng_mode;
  logic [N-1:0] eng_data_in;
  logic [N-1:0] eng_data_out = '0;
  logic         eng_done = 1'b0;
  logic         rsp_valid, rsp_mode, rsp_err, busy;
  logic         rsp_ready = 1'b0;
  logic [N-1:0] rsp_data;
  logic         hang = 1'b0;
  int           lat = 0;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  rsa_engine_arbiter #(.N_BIT(N), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .enc_req_valid(enc_req_valid), .enc_req_ready(enc_req_ready), .enc_req_data(enc_req_data),
    .dec_req_valid(dec_req_valid), .dec_req_ready(dec_req_ready), .dec_req_data(dec_req_data),
    .eng_start(eng_start), .eng_mode(eng_mode), .eng_data_in(eng_data_in),
    .eng_data_out(eng_data_out), .eng_done(eng_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mode(rsp_mode),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic [N-1:0] modexp(input logic [N-1:0] b, input logic m);
    longint r = 1;
    longint x = longint'(b);
    int     ex = m ? 1373 : 5;
    while (ex > 0) begin
      if (ex[0]) r = (r * x) % 3551;
      x  = (x * x) % 3551;
      ex = ex >> 1;
    end
    return N'(r);
  endfunction

  // Engine: done 20 cycles after start, held until start drops.
  always @(posedge clk) begin
    if (!eng_start) begin
      lat      <= 0;
      eng_done <= 1'b0;
    end else if (!eng_done && !hang) begin
      if (lat == 19) begin
        eng_done     <= 1'b1;
        eng_data_out <= modexp(eng_data_in, eng_mode);
      end else begin
        lat <= lat + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
    chk(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin step(); n++; end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset held with both requests valid
    enc_req_valid = 1'b1; enc_req_data = 12'd42;
    dec_req_valid = 1'b1; dec_req_data = 12'd228;
    #1;
    repeat (3) step();
    chk("rst_eng_start", 32'(eng_start), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_enc_ready", 32'(enc_req_ready), 0);
    chk("rst_dec_ready", 32'(dec_req_ready), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);

    // 2: encrypt alone
    dec_req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("t2_enc_ready", 32'(enc_req_ready), 1);
    chk("t2_start_pre", 32'(eng_start), 0);
    step();
    enc_req_valid = 1'b0;
    #1;
    chk("t2_enc_ready_off", 32'(enc_req_ready), 0);
    chk("t2_start", 32'(eng_start), 1);
    chk("t2_mode", 32'(eng_mode), 0);
    chk("t2_data_in", 32'(eng_data_in), 42);
    chk("t2_busy", 32'(busy), 1);
    wait_rsp("t2_rsp_wait");
    chk("t2_rsp_data", 32'(rsp_data), 228);
    chk("t2_rsp_mode", 32'(rsp_mode), 0);
    chk("t2_rsp_err", 32'(rsp_err), 0);
    chk("t2_start_off", 32'(eng_start), 0);
    take_rsp();
    wait_idle("t2_idle");

    // 3: simultaneous requests after reset, encrypt first
    rst_n = 1'b0;
    repeat (2) step();
    enc_req_valid = 1'b1; enc_req_data = 12'd42;
    dec_req_valid = 1'b1; dec_req_data = 12'd228;
    rst_n = 1'b1;
    #1;
    chk("t3_enc_ready", 32'(enc_req_ready), 1);
    chk("t3_dec_ready", 32'(dec_req_ready), 0);
    step();
    enc_req_valid = 1'b0;
    #1;
    chk("t3_mode_enc", 32'(eng_mode), 0);
    chk("t3_dec_wait", 32'(dec_req_ready), 0);
    wait_rsp("t3_rsp1_wait");
    chk("t3_rsp1_data", 32'(rsp_data), 228);
    chk("t3_rsp1_mode", 32'(rsp_mode), 0);
    chk("t3_dec_blocked", 32'(dec_req_ready), 0);
    take_rsp();
    begin
      int n = 0;
      while (dec_req_ready !== 1'b1 && n < 20) begin step(); n++; end
    end
    chk("t3_dec_ready2", 32'(dec_req_ready), 1);
    step();
    dec_req_valid = 1'b0;
    #1;
    chk("t3_mode_dec", 32'(eng_mode), 1);
    chk("t3_data_dec", 32'(eng_data_in), 228);
    wait_rsp("t3_rsp2_wait");
    chk("t3_rsp2_data", 32'(rsp_data), 42);
    chk("t3_rsp2_mode", 32'(rsp_mode), 1);
    take_rsp();
    wait_idle("t3_idle");

    // 4: next tie goes to encrypt; response stalled 10 cycles
    enc_req_valid = 1'b1; dec_req_valid = 1'b1;
    #1;
    chk("t4_tie_enc", 32'(enc_req_ready), 1);
    chk("t4_tie_dec", 32'(dec_req_ready), 0);
    step();
    enc_req_valid = 1'b0;
    wait_rsp("t4_rsp_wait");
    begin
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
        if (rsp_valid !== 1'b1 || rsp_data !== 12'd228 || rsp_mode !== 1'b0 ||
            dec_req_ready !== 1'b0 || eng_start !== 1'b0) bad++;
        step();
      end
      chk("t4_stall_stable", 32'(bad), 0);
    end
    chk("t4_rsp_data", 32'(rsp_data), 228);
    take_rsp();
    begin
      int n = 0;
      while (dec_req_ready !== 1'b1 && n < 20) begin step(); n++; end
    end
    step();
    dec_req_valid = 1'b0;
    wait_rsp("t4_rsp2_wait");
    chk("t4_rsp2_data", 32'(rsp_data), 42);
    chk("t4_rsp2_mode", 32'(rsp_mode), 1);
    take_rsp();
    wait_idle("t4_idle");

    // 5: reset mid-job at RUN cycle 10
    enc_req_valid = 1'b1; enc_req_data = 12'd42;
    step();
    enc_req_valid = 1'b0;
    repeat (9) step();
    chk("t5_running", 32'(eng_start), 1);
    rst_n = 1'b0;
    step();
    chk("t5_start_off", 32'(eng_start), 0);
    chk("t5_no_rsp", 32'(rsp_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (2) step();
    chk("t5_still_no_rsp", 32'(rsp_valid), 0);
    enc_req_valid = 1'b1;
    step();
    enc_req_valid = 1'b0;
    wait_rsp("t5_rsp_wait");
    chk("t5_rsp_data", 32'(rsp_data), 228);
    chk("t5_rsp_mode", 32'(rsp_mode), 0);
    take_rsp();
    wait_idle("t5_idle");

`ifdef RSA_ARB_TIMEOUT_EN
    // 6: engine never finishes; watchdog aborts at RUN cycle 100
    hang = 1'b1;
    enc_req_valid = 1'b1;
    step();
    enc_req_valid = 1'b0;
    repeat (99) step();
    chk("t6_pre_timeout", 32'(rsp_valid), 0);
    step();
    chk("t6_rsp_valid", 32'(rsp_valid), 1);
    chk("t6_rsp_err", 32'(rsp_err), 1);
    chk("t6_rsp_data", 32'(rsp_data), 0);
    chk("t6_start_off", 32'(eng_start), 0);
    take_rsp();
    chk("t6_err_clear", 32'(rsp_err), 0);
    wait_idle("t6_idle");
    hang = 1'b0;
    enc_req_valid = 1'b1;
    step();
    enc_req_valid = 1'b0;
    wait_rsp("t6_rsp2_wait");
    chk("t6_rsp2_data", 32'(rsp_data), 228);
    chk("t6_rsp2_err", 32'(rsp_err), 0);
    take_rsp();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
